// File: rtl/soc_decerr_slave_pkg.sv
// rtl/soc_decerr_slave_pkg.sv - shared types and constants for the default-port DECERR responder
package soc_decerr_slave_pkg;

    localparam logic [63:0] ErrSlvData  = 64'hBADC_AB1E_BADC_AB1E;
    localparam int unsigned ErrCntWidth = 16;
    localparam logic [1:0]  RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_e;
    typedef enum logic       {R_IDLE, R_DATA}         rd_state_e;

    // Sticks at all-ones instead of wrapping so a flood of stray accesses stays visible.
    function automatic logic [ErrCntWidth-1:0] sat_add(input logic [ErrCntWidth-1:0] a,
                                                       input logic [1:0]             inc);
        logic [ErrCntWidth:0] sum;
        sum = {1'b0, a} + {{(ErrCntWidth-1){1'b0}}, inc};
        return sum[ErrCntWidth] ? '1 : sum[ErrCntWidth-1:0];
    endfunction

endpackage

// File: rtl/soc_decerr_rd_chan.sv
// rtl/soc_decerr_rd_chan.sv - read channel: accepts one AR, returns len+1 DECERR beats
module soc_decerr_rd_chan
    import soc_decerr_slave_pkg::*;
#(
    parameter int unsigned          IdWidth   = 5,
    parameter int unsigned          DataWidth = 64,
    parameter logic [DataWidth-1:0] ErrData   = '0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 ar_valid_i,
    output logic                 ar_ready_o,
    input  logic [IdWidth-1:0]   ar_id_i,
    input  logic [7:0]           ar_len_i,
    output logic                 r_valid_o,
    input  logic                 r_ready_i,
    output logic [IdWidth-1:0]   r_id_o,
    output logic [DataWidth-1:0] r_data_o,
    output logic [1:0]           r_resp_o,
    output logic                 r_last_o
);

    rd_state_e            state_q;
    logic                 ar_ready_q;
    logic                 r_valid_q;
    logic                 r_last_q;
    logic [IdWidth-1:0]   id_q;
    logic [7:0]           len_q;
    logic [7:0]           cnt_q;
    logic [7:0]           cnt_d;

    assign cnt_d = cnt_q + 8'd1;

    // r_last is precomputed one beat ahead so it stays a plain register output.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= R_IDLE;
            ar_ready_q <= 1'b1;
            r_valid_q  <= 1'b0;
            r_last_q   <= 1'b0;
            id_q       <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
        end else begin
            case (state_q)
                R_IDLE: begin
                    if (ar_valid_i && ar_ready_q) begin
                        id_q       <= ar_id_i;
                        len_q      <= ar_len_i;
                        cnt_q      <= '0;
                        r_last_q   <= (ar_len_i == 8'd0);
                        r_valid_q  <= 1'b1;
                        ar_ready_q <= 1'b0;
                        state_q    <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (r_ready_i) begin
                        if (r_last_q) begin
                            r_valid_q  <= 1'b0;
                            r_last_q   <= 1'b0;
                            ar_ready_q <= 1'b1;
                            state_q    <= R_IDLE;
                        end else begin
                            cnt_q    <= cnt_d;
                            r_last_q <= (cnt_d == len_q);
                        end
                    end
                end
            endcase
        end
    end

    assign ar_ready_o = ar_ready_q;
    assign r_valid_o  = r_valid_q;
    assign r_last_o   = r_last_q;
    assign r_id_o     = id_q;
    assign r_data_o   = ErrData;
    assign r_resp_o   = RESP_DECERR;

endmodule

// File: rtl/soc_decerr_slave.sv
// rtl/soc_decerr_slave.sv - AXI4 default-port responder answering every access with DECERR
module soc_decerr_slave
    import soc_decerr_slave_pkg::*;
#(
    parameter int unsigned IdWidth   = 5,
    parameter int unsigned AddrWidth = 64,
    parameter int unsigned DataWidth = 64,
    parameter logic [63:0] ErrData   = ErrSlvData
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   aw_valid_i,
    output logic                   aw_ready_o,
    input  logic [IdWidth-1:0]     aw_id_i,
    input  logic [AddrWidth-1:0]   aw_addr_i,
    input  logic                   w_valid_i,
    output logic                   w_ready_o,
    input  logic                   w_last_i,
    output logic                   b_valid_o,
    input  logic                   b_ready_i,
    output logic [IdWidth-1:0]     b_id_o,
    output logic [1:0]             b_resp_o,
    input  logic                   ar_valid_i,
    output logic                   ar_ready_o,
    input  logic [IdWidth-1:0]     ar_id_i,
    input  logic [AddrWidth-1:0]   ar_addr_i,
    input  logic [7:0]             ar_len_i,
    output logic                   r_valid_o,
    input  logic                   r_ready_i,
    output logic [IdWidth-1:0]     r_id_o,
    output logic [DataWidth-1:0]   r_data_o,
    output logic [1:0]             r_resp_o,
    output logic                   r_last_o,
    output logic                   err_o,
    output logic [AddrWidth-1:0]   err_addr_o,
    output logic [ErrCntWidth-1:0] err_cnt_o
);

    localparam logic [DataWidth-1:0] ErrDataTrunc = ErrData[DataWidth-1:0];

    wr_state_e              wr_state_q;
    logic                   aw_ready_q;
    logic                   w_ready_q;
    logic                   b_valid_q;
    logic [IdWidth-1:0]     b_id_q;
    logic                   err_q;
    logic [AddrWidth-1:0]   err_addr_q;
    logic [ErrCntWidth-1:0] err_cnt_q;
    logic [ErrCntWidth-1:0] err_cnt_d;
    logic                   aw_hs;
    logic                   ar_hs;

    assign aw_hs = aw_valid_i && aw_ready_q;
    assign ar_hs = ar_valid_i && ar_ready_o;

    // w_last is authoritative for burst end; the AW length is never looked at.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_state_q <= W_IDLE;
            aw_ready_q <= 1'b1;
            w_ready_q  <= 1'b0;
            b_valid_q  <= 1'b0;
            b_id_q     <= '0;
        end else begin
            case (wr_state_q)
                W_IDLE: begin
                    if (aw_hs) begin
                        b_id_q     <= aw_id_i;
                        aw_ready_q <= 1'b0;
                        w_ready_q  <= 1'b1;
                        wr_state_q <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_valid_i && w_last_i) begin
                        w_ready_q  <= 1'b0;
                        b_valid_q  <= 1'b1;
                        wr_state_q <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (b_ready_i) begin
                        b_valid_q  <= 1'b0;
                        aw_ready_q <= 1'b1;
                        wr_state_q <= W_IDLE;
                    end
                end
                default: begin
                    wr_state_q <= W_IDLE;
                    aw_ready_q <= 1'b1;
                    w_ready_q  <= 1'b0;
                    b_valid_q  <= 1'b0;
                end
            endcase
        end
    end

    assign err_cnt_d = sat_add(err_cnt_q, {1'b0, aw_hs} + {1'b0, ar_hs});

    // On a simultaneous AW/AR the write address is the one recorded.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_q      <= 1'b0;
            err_addr_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            err_q     <= aw_hs || ar_hs;
            err_cnt_q <= err_cnt_d;
            if (aw_hs) begin
                err_addr_q <= aw_addr_i;
            end else if (ar_hs) begin
                err_addr_q <= ar_addr_i;
            end
        end
    end

    soc_decerr_rd_chan #(
        .IdWidth   (IdWidth),
        .DataWidth (DataWidth),
        .ErrData   (ErrDataTrunc)
    ) u_rd_chan (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .ar_valid_i (ar_valid_i),
        .ar_ready_o (ar_ready_o),
        .ar_id_i    (ar_id_i),
        .ar_len_i   (ar_len_i),
        .r_valid_o  (r_valid_o),
        .r_ready_i  (r_ready_i),
        .r_id_o     (r_id_o),
        .r_data_o   (r_data_o),
        .r_resp_o   (r_resp_o),
        .r_last_o   (r_last_o)
    );

    assign aw_ready_o = aw_ready_q;
    assign w_ready_o  = w_ready_q;
    assign b_valid_o  = b_valid_q;
    assign b_id_o     = b_id_q;
    assign b_resp_o   = RESP_DECERR;
    assign err_o      = err_q;
    assign err_addr_o = err_addr_q;
    assign err_cnt_o  = err_cnt_q;

endmodule
